// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage with a direct-mapped, write-through,
// one-word-per-line data cache in front of a ready-handshaked backing memory.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   MemRead, MemWrite       load / store request from EX/MEM (both set = store)
//   address, writeData      byte address (bits [1:0] ignored) and store data
//   readData                load data to MEM/WB, zero unless completing a read hit
//   hit                     1 = access completes this cycle, 0 = freeze the pipeline
//   memReq, memWe           registered backing-memory request and write strobe
//   memAddr, memWData       word-aligned address and store data to backing memory
//   memRData, memReady      backing-memory read data and request completion
//   accessCount, missCount  wrapping statistics counters
module mem_access_stage #(
   parameter int unsigned INDEX_BITS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        hit,
   output logic        memReq,
   output logic        memWe,
   output logic [31:0] memAddr,
   output logic [31:0] memWData,
   input  logic [31:0] memRData,
   input  logic        memReady,
   output logic [15:0] accessCount,
   output logic [15:0] missCount
);

   localparam int unsigned Lines   = 1 << INDEX_BITS;
   localparam int unsigned TagBits = 30 - INDEX_BITS;

   typedef enum logic [1:0] {StIdle, StReadMiss, StWriteThru, StWDone} stateT;

   stateT                  stateQ;
   logic [Lines-1:0]       validQ;
   logic [TagBits-1:0]     tagQ  [Lines];
   logic [31:0]            dataQ [Lines];

   logic [INDEX_BITS-1:0]  index;
   logic [TagBits-1:0]     tag;
   logic                   match;
   logic                   wantWrite;
   logic                   wantRead;
   logic                   anyAccess;

   assign index     = address[INDEX_BITS+1:2];
   assign tag       = address[31:INDEX_BITS+2];
   assign match     = validQ[index] && (tagQ[index] == tag);
   assign wantWrite = MemWrite;
   assign wantRead  = MemRead & ~MemWrite;
   assign anyAccess = MemRead | MemWrite;

   // Inputs are held stable by the frozen pipeline while hit=0.
   assign memAddr  = address & ~32'd3;
   assign memWData = writeData;

   always_comb begin
      hit      = 1'b0;
      readData = 32'd0;
      unique case (stateQ)
         StIdle: begin
            if (wantWrite) begin
               hit = 1'b0;
            end else if (wantRead) begin
               hit = match;
               if (match) readData = dataQ[index];
            end else begin
               hit = 1'b1;
            end
         end
         // Store retires here without going back through the lookup.
         StWDone: hit = 1'b1;
         default: hit = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stateQ      <= StIdle;
         validQ      <= '0;
         memReq      <= 1'b0;
         memWe       <= 1'b0;
         accessCount <= 16'd0;
         missCount   <= 16'd0;
      end else begin
         unique case (stateQ)
            StIdle: begin
               if (wantWrite) begin
                  // Write-update on match, no allocate on miss.
                  if (match) dataQ[index] <= writeData;
                  stateQ <= StWriteThru;
                  memReq <= 1'b1;
                  memWe  <= 1'b1;
               end else if (wantRead) begin
                  if (match) begin
                     accessCount <= accessCount + 16'd1;
                  end else begin
                     missCount <= missCount + 16'd1;
                     stateQ    <= StReadMiss;
                     memReq    <= 1'b1;
                     memWe     <= 1'b0;
                  end
               end
            end
            StReadMiss: begin
               if (memReady) begin
                  validQ[index] <= 1'b1;
                  tagQ[index]   <= tag;
                  dataQ[index]  <= memRData;
                  stateQ        <= StIdle;
                  memReq        <= 1'b0;
               end
            end
            StWriteThru: begin
               if (memReady) begin
                  stateQ <= StWDone;
                  memReq <= 1'b0;
                  memWe  <= 1'b0;
               end
            end
            StWDone: begin
               if (anyAccess) accessCount <= accessCount + 16'd1;
               stateQ <= StIdle;
            end
            default: stateQ <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed accesses with literal expectations, plus a
// transaction-level cache model compared against the DUT outputs on every falling edge.
module tb_mem_access_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        hit;
   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWData;
   logic [31:0] memRData;
   logic        memReady;
   logic [15:0] accessCount;
   logic [15:0] missCount;

   int errors = 0;
   int checks = 0;

   mem_access_stage #(.INDEX_BITS(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .address     (address),
      .writeData   (writeData),
      .readData    (readData),
      .hit         (hit),
      .memReq      (memReq),
      .memWe       (memWe),
      .memAddr     (memAddr),
      .memWData    (memWData),
      .memRData    (memRData),
      .memReady    (memReady),
      .accessCount (accessCount),
      .missCount   (missCount)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each of the 16 lines remembers which word address it holds and its data.
   bit          started = 0;
   bit          mValid [16];
   logic [29:0] mWord  [16];
   logic [31:0] mData  [16];
   bit          mMissOut;   // read miss outstanding at the backing memory
   bit          mWriteOut;  // write-through outstanding
   bit          mRetire;    // store retiring this cycle
   int          mAcc;
   int          mMiss;

   function automatic bit lineHolds(input logic [31:0] a);
      return mValid[a[5:2]] && (mWord[a[5:2]] == a[31:2]);
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         started   = 1;
         mMissOut  = 0;
         mWriteOut = 0;
         mRetire   = 0;
         mAcc      = 0;
         mMiss     = 0;
         for (int i = 0; i < 16; i++) mValid[i] = 0;
      end else if (started) begin
         if (mMissOut) begin
            if (memReady) begin
               mValid[address[5:2]] = 1;
               mWord[address[5:2]]  = address[31:2];
               mData[address[5:2]]  = memRData;
               mMissOut = 0;
            end
         end else if (mWriteOut) begin
            if (memReady) begin
               mWriteOut = 0;
               mRetire   = 1;
            end
         end else if (mRetire) begin
            if (MemRead || MemWrite) mAcc = (mAcc + 1) % 65536;
            mRetire = 0;
         end else if (MemWrite) begin
            if (lineHolds(address)) mData[address[5:2]] = writeData;
            mWriteOut = 1;
         end else if (MemRead) begin
            if (lineHolds(address)) mAcc = (mAcc + 1) % 65536;
            else begin
               mMiss    = (mMiss + 1) % 65536;
               mMissOut = 1;
            end
         end
      end
   end

   always @(negedge clock) begin
      logic        eHit;
      logic [31:0] eRd;
      if (started) begin
         eRd = 32'd0;
         if (mMissOut || mWriteOut)  eHit = 1'b0;
         else if (mRetire)           eHit = 1'b1;
         else if (MemWrite)          eHit = 1'b0;
         else if (MemRead) begin
            eHit = lineHolds(address);
            if (eHit) eRd = mData[address[5:2]];
         end else                    eHit = 1'b1;
         check("model.hit", {31'd0, hit}, {31'd0, eHit});
         check("model.readData", readData, eRd);
         check("model.memReq", {31'd0, memReq}, {31'd0, (mMissOut || mWriteOut)});
         check("model.memWe", {31'd0, memWe}, {31'd0, mWriteOut});
         check("model.accessCount", {16'd0, accessCount}, mAcc);
         check("model.missCount", {16'd0, missCount}, mMiss);
         if (mMissOut || mWriteOut) check("model.memAddr", memAddr, {address[31:2], 2'b00});
         if (mWriteOut) check("model.memWData", memWData, writeData);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Presents one access and serves it; memReady is raised in the nth request cycle.
   // Returns at the falling edge of the cycle where hit=1.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int nth, input logic [31:0] rdata,
                         output int stalls, output logic lastWe);
      int reqs;
      bit done;
      MemRead   = rd;
      MemWrite  = wr;
      address   = addr;
      writeData = wd;
      stalls = 0;
      reqs   = 0;
      lastWe = 1'b0;
      done   = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clock);
         if (hit === 1'b1) done = 1;
         else begin
            stalls++;
            if (memReq === 1'b1) begin
               reqs++;
               lastWe = memWe;
               if (reqs == nth) begin
                  memReady = 1'b1;
                  memRData = rdata;
               end
            end
            step();
            memReady = 1'b0;
            memRData = 32'd0;
         end
      end
      if (!done) check("accessTimeout", {31'd0, hit}, 32'd1);
   endtask

   initial begin
      int   st;
      logic we;
      reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; address = 32'd0; writeData = 32'd0;
      memRData = 32'd0; memReady = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst.hit", {31'd0, hit}, 32'd1);
      check("rst.memReq", {31'd0, memReq}, 32'd0);
      check("rst.readData", readData, 32'd0);
      check("rst.accessCount", {16'd0, accessCount}, 32'd0);
      check("rst.missCount", {16'd0, missCount}, 32'd0);

      step();
      access(1'b1, 1'b0, 32'h40, 32'd0, 3, 32'hDEADBEEF, st, we);
      check("rdMiss.stalls", st, 32'd4);
      check("rdMiss.readData", readData, 32'hDEADBEEF);
      check("rdMiss.missCount", {16'd0, missCount}, 32'd1);
      check("rdMiss.memWe", {31'd0, we}, 32'd0);

      step();
      access(1'b1, 1'b0, 32'h40, 32'd0, 0, 32'd0, st, we);
      check("rdHit.stalls", st, 32'd0);
      check("rdHit.readData", readData, 32'hDEADBEEF);

      step();
      access(1'b0, 1'b1, 32'h40, 32'h12345678, 1, 32'd0, st, we);
      check("wr.stalls", st, 32'd2);
      check("wr.memWe", {31'd0, we}, 32'd1);
      check("wr.accessCount", {16'd0, accessCount}, 32'd2);

      step();
      access(1'b1, 1'b0, 32'h40, 32'd0, 0, 32'd0, st, we);
      check("wrRd.stalls", st, 32'd0);
      check("wrRd.readData", readData, 32'h12345678);

      step();
      access(1'b1, 1'b0, 32'h80, 32'd0, 1, 32'hCAFEF00D, st, we);
      check("conflict80.stalls", st, 32'd2);
      check("conflict80.readData", readData, 32'hCAFEF00D);
      check("conflict80.missCount", {16'd0, missCount}, 32'd2);

      step();
      access(1'b1, 1'b0, 32'h40, 32'd0, 2, 32'h12345678, st, we);
      check("conflict40.stalls", st, 32'd3);
      check("conflict40.readData", readData, 32'h12345678);
      check("conflict40.missCount", {16'd0, missCount}, 32'd3);

      // Reset while a read miss to 0x80 (evicted above) is outstanding.
      step();
      MemRead = 1'b1; address = 32'h80;
      @(negedge clock);
      check("rstMid.detectHit", {31'd0, hit}, 32'd0);
      step();
      @(negedge clock);
      check("rstMid.memReqBefore", {31'd0, memReq}, 32'd1);
      reset = 1'b1;
      MemRead = 1'b0;
      step();
      reset = 1'b0;
      @(negedge clock);
      check("rstMid.memReqAfter", {31'd0, memReq}, 32'd0);
      check("rstMid.accessCount", {16'd0, accessCount}, 32'd0);
      check("rstMid.missCount", {16'd0, missCount}, 32'd0);
      check("rstMid.hit", {31'd0, hit}, 32'd1);

      step();
      access(1'b1, 1'b0, 32'h40, 32'd0, 1, 32'h11111111, st, we);
      check("postRst.stalls", st, 32'd2);
      check("postRst.missCount", {16'd0, missCount}, 32'd1);
      check("postRst.readData", readData, 32'h11111111);

      step();
      access(1'b1, 1'b1, 32'h44, 32'hAABBCCDD, 2, 32'd0, st, we);
      check("rw.stalls", st, 32'd3);
      check("rw.memWe", {31'd0, we}, 32'd1);
      check("rw.missCount", {16'd0, missCount}, 32'd1);

      step();
      MemRead = 1'b0; MemWrite = 1'b0;
      @(negedge clock);
      check("end.accessCount", {16'd0, accessCount}, 32'd2);
      check("end.memReq", {31'd0, memReq}, 32'd0);
      repeat (2) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage that consumes the EX/MEM pipeline register outputs and performs loads and stores through a direct-mapped, write-through, one-word-per-line data cache backed by an external memory with a ready handshake. It drives `hit`, which the pipeline registers use as their advance enable: `hit`=0 freezes the pipeline while a miss or a write-through is outstanding. It also produces the load data forwarded to MEM/WB and keeps access and miss statistics counters.

## Interface
- `INDEX_BITS`, default 4: cache index width; the cache has 2^INDEX_BITS lines of 32 bits.
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `MemRead`  in  1  load request from EX/MEM.
- `MemWrite`  in  1  store request from EX/MEM.
- `address`  in  32  byte address (ALUResultOut); bits [1:0] ignored.
- `writeData`  in  32  store data (readData2Out).
- `readData`  out  32  load data to MEM/WB.
- `hit`  out  1  1 = stage can complete this cycle; 0 = stall.
- `memReq`  out  1  backing-memory request, registered.
- `memWe`  out  1  1 = write request, 0 = read; registered.
- `memAddr`  out  32  word-aligned address {address[31:2],2'b00}.
- `memWData`  out  32  write data to backing memory.
- `memRData`  in  32  read data, valid when memReady=1.
- `memReady`  in  1  completes the outstanding request this cycle.
- `accessCount`  out  16  completed MemRead/MemWrite accesses, wraps.
- `missCount`  out  16  read misses, wraps.

## Operation
- Address split: index = address[INDEX_BITS+1:2], tag = address[31:INDEX_BITS+2]. Each line holds a valid bit, a tag and 32 data bits.
- Lookup match = valid[index] && tag[index] == tag.
- An access with both MemRead and MemWrite set is treated as a write.
- States:
  - IDLE:
    - No access: hit=1.
    - Read with match: hit=1, readData = line data.
    - Read without match: hit=0; next state READ_MISS; missCount+1.
    - Write: hit=0; next state WRITE_THRU. If the line matches, its data is updated to writeData on this edge (write-update, no allocate on miss).
  - READ_MISS:
    - hit=0, memReq=1, memWe=0.
    - On memReady=1: the line is filled with valid=1, the new tag and memRData; next state IDLE. The re-lookup then matches and hit=1.
  - WRITE_THRU:
    - hit=0, memReq=1, memWe=1, memWData=writeData.
    - On memReady=1: next state WDONE.
  - WDONE: hit=1 for one cycle so the store retires without re-issue; next state IDLE.
- accessCount increments on every cycle where hit=1 and (MemRead|MemWrite) in IDLE or WDONE.
- readData = 0 whenever the stage is not completing a read hit.
- memReady is ignored in IDLE and WDONE.
- memAddr/memWData are driven from the inputs. The inputs are stable while hit=0 because the pipeline is frozen.

## Timing
- Reset (posedge, reset=1):
  - state=IDLE, all valid bits cleared, memReq=0, memWe=0, accessCount=0, missCount=0.
  - Outputs after reset: hit=1 when no access is present, readData=0.
- Reset mid-operation (READ_MISS or WRITE_THRU) aborts the transaction: memReq is 0 from the next cycle, no line fill, no counter update.
- Read hit: zero stall cycles; readData and hit are combinational in the same cycle.
- Read miss: memReq is asserted from the cycle after detection until memReady is sampled high.
  - The stall lasts 2+N cycles for N cycles of memReq before memReady: the detect cycle, N request cycles and the ready cycle, then the hit in IDLE.
- Write: stall of 1+N+1 cycles, then WDONE with hit=1.
- memReq never re-asserts in the cycle after memReady without a new access passing through IDLE.
- `hit` is combinational and stable before the falling edge, where the EX/MEM and MEM/WB registers sample it.

## Test plan
- Reset with no access -> hit=1, memReq=0, readData=0, accessCount=0, missCount=0.
- Read 0x40, memory answers 0xDEADBEEF with memReady in the 3rd request cycle:
  - hit=0 for 4 cycles, then hit=1 with readData=0xDEADBEEF, missCount=1.
  - An immediate second read of 0x40 returns hit=1 in the same cycle.
- Write 0x12345678 to cached 0x40:
  - memReq=1, memWe=1, memAddr=0x40, memWData=0x12345678 until memReady, then one WDONE cycle with hit=1.
  - A following read of 0x40 hits with 0x12345678.
- Conflict: read 0x80 after 0x40 is cached (same index 0, tag 2 vs 1):
  - Miss and refill.
  - Re-reading 0x40 misses again; missCount increments each time.
- Reset asserted during READ_MISS:
  - memReq=0 next cycle, no fill.
  - A read of 0x40 afterwards misses; counters read 0.
- MemRead=1 and MemWrite=1 to 0x44 -> write-through path (memWe=1); no read miss is counted.
